// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - per-beat AXI burst address generator (FIXED/INCR/WRAP, illegal-burst flag)
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [SIZE_WIDTH-1:0]  cmd_size,
  input  logic [BURST_WIDTH-1:0] cmd_burst,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic [ADDR_WIDTH-1:0]  beat_addr,
  output logic                   beat_last,
  output logic                   beat_err
);

  localparam int          NBYTES = DATA_WIDTH / 8;
  localparam logic [31:0] NB_LOG = $clog2(NBYTES);
  localparam int          W      = ADDR_WIDTH + 1;

  localparam logic [BURST_WIDTH-1:0] B_FIXED = BURST_WIDTH'(0);
  localparam logic [BURST_WIDTH-1:0] B_INCR  = BURST_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] B_WRAP  = BURST_WIDTH'(2);
  localparam logic [BURST_WIDTH-1:0] B_RSVD  = BURST_WIDTH'(3);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_next;
  logic [LEN_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  bytes_q;
  logic [ADDR_WIDTH-1:0]  wrap_lo;
  logic [ADDR_WIDTH-1:0]  wrap_end;
  logic [BURST_WIDTH-1:0] mode_q;
  logic                   last_q;
  logic                   err_q;

  logic accept;
  logic handshake;

  // Command decode: sizes and spans kept one bit wider than the address.
  logic [W-1:0]          c_bytes;
  logic [W-1:0]          c_mask;
  logic [W-1:0]          c_beats;
  logic [W-1:0]          c_total;
  logic [W-1:0]          c_span;
  logic [ADDR_WIDTH-1:0] c_tmask;
  logic [ADDR_WIDTH-1:0] c_wrap_lo;
  logic                  c_size_bad;
  logic                  c_wrap_len_bad;
  logic                  c_unaligned;
  logic                  c_cross;
  logic                  c_err;

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign accept    = cmd_valid && (state == IDLE);
  assign handshake = beat_ready && (state == BURST);

  assign c_bytes        = W'(1) << cmd_size;
  assign c_mask         = c_bytes - W'(1);
  assign c_beats        = W'(cmd_len) + W'(1);
  assign c_total        = c_bytes * c_beats;
  assign c_span         = (W'(cmd_addr[11:0]) & ~c_mask) + c_total;
  assign c_cross        = c_span > W'(4096);
  assign c_size_bad     = 32'(cmd_size) > NB_LOG;
  assign c_wrap_len_bad = !((cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                            (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15)));
  assign c_unaligned    = (W'(cmd_addr) & c_mask) != '0;
  assign c_tmask        = c_total[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign c_wrap_lo      = cmd_addr & ~c_tmask;

  assign c_err = (cmd_burst == B_RSVD) || c_size_bad ||
                 ((cmd_burst == B_WRAP) && (c_wrap_len_bad || c_unaligned)) ||
                 ((cmd_burst == B_INCR) && c_cross);

  always_comb begin
    incr_addr = addr_q + bytes_q;
    next_addr = addr_q;
    case (mode_q)
      B_INCR:  next_addr = (addr_q & ~(bytes_q - ADDR_WIDTH'(1))) + bytes_q;
      B_WRAP:  next_addr = (incr_addr == wrap_end) ? wrap_lo : incr_addr;
      default: next_addr = addr_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = BURST;
      BURST:   if (beat_ready && last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt      <= '0;
      addr_q   <= '0;
      bytes_q  <= '0;
      wrap_lo  <= '0;
      wrap_end <= '0;
      mode_q   <= B_FIXED;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      cnt      <= cmd_len;
      addr_q   <= cmd_addr;
      bytes_q  <= c_bytes[ADDR_WIDTH-1:0];
      wrap_lo  <= c_wrap_lo;
      wrap_end <= c_wrap_lo + c_total[ADDR_WIDTH-1:0];
      // Illegal bursts still run their full beat count, but with the address pinned.
      mode_q   <= c_err ? B_FIXED : cmd_burst;
      err_q    <= c_err;
      last_q   <= (cmd_len == '0);
    end else if (handshake) begin
      if (last_q) begin
        last_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt    <= cnt - LEN_WIDTH'(1);
        addr_q <= next_addr;
        last_q <= (cnt == LEN_WIDTH'(1));
      end
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign beat_valid = (state == BURST);
  assign beat_addr  = addr_q;
  assign beat_last  = last_q;
  assign beat_err   = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb/tb_axi_burst_addr_gen.sv - directed self-checking bench for axi_burst_addr_gen
module tb_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic        beat_last;
  logic        beat_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_burst_addr_gen dut (
    .ACLK       (clk),
    .ARESETn    (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_last  (beat_last),
    .beat_err   (beat_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " beat_valid"}, 32'(beat_valid), 32'd0);
  endtask

  // Called on a falling edge while idle; returns on the falling edge after acceptance.
  task automatic send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst);
    check_idle("pre-cmd");
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic last, input logic err);
    beat_ready = 1'b1;
    check("beat_valid", 32'(beat_valid), 32'd1);
    check("beat_addr", beat_addr, a);
    check("beat_last", 32'(beat_last), 32'(last));
    check("beat_err", 32'(beat_err), 32'(err));
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst beat_valid", 32'(beat_valid), 32'd0);
    check("rst beat_addr", beat_addr, 32'd0);
    check("rst beat_last", 32'(beat_last), 32'd0);
    check("rst beat_err", 32'(beat_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // INCR, unaligned start
    send(32'h1002, 8'd3, 3'd2, 2'b01);
    beat(32'h1002, 1'b0, 1'b0);
    beat(32'h1004, 1'b0, 1'b0);
    beat(32'h1008, 1'b0, 1'b0);
    beat(32'h100C, 1'b1, 1'b0);

    // WRAP crossing the 16-byte window
    send(32'h0038, 8'd3, 3'd2, 2'b10);
    beat(32'h38, 1'b0, 1'b0);
    beat(32'h3C, 1'b0, 1'b0);
    beat(32'h30, 1'b0, 1'b0);
    beat(32'h34, 1'b1, 1'b0);
    check_idle("wrap gap");

    // FIXED, with a second command held pending during the burst
    send(32'h0040, 8'd2, 3'd1, 2'b00);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h500;
    cmd_len   = 8'd0;
    cmd_size  = 3'd2;
    cmd_burst = 2'b01;
    beat(32'h40, 1'b0, 1'b0);
    beat(32'h40, 1'b0, 1'b0);
    beat(32'h40, 1'b1, 1'b0);
    check_idle("pending gap");
    @(negedge clk);
    cmd_valid = 1'b0;
    beat(32'h500, 1'b1, 1'b0);

    // INCR with backpressure on beat 3
    send(32'h0, 8'd7, 3'd2, 2'b01);
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h4, 1'b0, 1'b0);
    beat_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp valid", 32'(beat_valid), 32'd1);
      check("bp addr", beat_addr, 32'h8);
      check("bp last", 32'(beat_last), 32'd0);
      @(negedge clk);
    end
    beat(32'h08, 1'b0, 1'b0);
    beat(32'h0C, 1'b0, 1'b0);
    beat(32'h10, 1'b0, 1'b0);
    beat(32'h14, 1'b0, 1'b0);
    beat(32'h18, 1'b0, 1'b0);
    beat(32'h1C, 1'b1, 1'b0);

    // Reserved burst type
    send(32'h80, 8'd1, 3'd2, 2'b11);
    beat(32'h80, 1'b0, 1'b1);
    beat(32'h80, 1'b1, 1'b1);

    // INCR crossing 4 KB
    send(32'h0FF8, 8'd3, 3'd2, 2'b01);
    beat(32'hFF8, 1'b0, 1'b1);
    beat(32'hFF8, 1'b0, 1'b1);
    beat(32'hFF8, 1'b0, 1'b1);
    beat(32'hFF8, 1'b1, 1'b1);

    // Beat size wider than the 32-bit memory
    send(32'h200, 8'd1, 3'd3, 2'b01);
    beat(32'h200, 1'b0, 1'b1);
    beat(32'h200, 1'b1, 1'b1);

    // WRAP with an unsupported length
    send(32'h40, 8'd2, 3'd2, 2'b10);
    beat(32'h40, 1'b0, 1'b1);
    beat(32'h40, 1'b0, 1'b1);
    beat(32'h40, 1'b1, 1'b1);

    // 256-beat INCR ending exactly on the 4 KB boundary is legal
    send(32'h0F00, 8'd255, 3'd0, 2'b01);
    for (int i = 0; i < 256; i++) beat(32'h0F00 + 32'(i), (i == 255), 1'b0);

    // Asynchronous reset during beat 2
    send(32'h0, 8'd7, 3'd2, 2'b01);
    beat(32'h0, 1'b0, 1'b0);
    check("pre-rst addr", beat_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    check("arst beat_valid", 32'(beat_valid), 32'd0);
    check("arst cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst beat_addr", beat_addr, 32'd0);
    check("arst beat_last", 32'(beat_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst no replay", 32'(beat_valid), 32'd0);
    send(32'h100, 8'd0, 3'd2, 2'b01);
    beat(32'h100, 1'b1, 1'b0);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
